// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types and constants for the two-master memory arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;

  function automatic logic [1:0] owner_grant(input owner_t owner);
    return (owner == OWN_M0) ? 2'b01 : 2'b10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_timeout.sv
// ============================================================================
// mem_timeout : BUSY wait counter; expired flags the last allowed wait cycle
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset, clear, tick};
      assign expired       = 1'b0;
    end else begin : g_enabled
      localparam int            CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

      logic [CW-1:0] count;

      // Saturates at LIMIT so a stalled exit can never wrap the counter.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (tick && (count != LIMIT)) begin
          count <= count + 1'b1;
        end
      end

      assign expired = (count == LIMIT);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : round-robin two-master / one-slave valid-ready bus arbiter
//               with a watchdog that force-completes unanswered requests
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic [1:0]  grant,
  output logic        bus_err
);

  state_t state;
  owner_t owner;
  owner_t last_owner;
  owner_t winner;

  logic        sel_valid;
  logic        sel_instr;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;

  logic        busy;
  logic        done_ok;
  logic        abandon;
  logic        expired;
  logic        timed_out;
  logic        finish;
  logic [31:0] resp_data;

  always_comb begin
    winner = OWN_M0;
    if (m0_valid && m1_valid) begin
      winner = (last_owner == OWN_M1) ? OWN_M0 : OWN_M1;
    end else if (m1_valid) begin
      winner = OWN_M1;
    end
  end

  always_comb begin
    sel_valid = m0_valid;
    sel_instr = m0_instr;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    sel_wstrb = m0_wstrb;
    if (owner == OWN_M1) begin
      sel_valid = m1_valid;
      sel_instr = m1_instr;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
      sel_wstrb = m1_wstrb;
    end
  end

  // A slave acknowledge beats both abandon and watchdog in the same cycle.
  assign busy      = (state == BUSY);
  assign done_ok   = busy & mem_ready;
  assign abandon   = busy & ~sel_valid & ~mem_ready;
  assign timed_out = busy & sel_valid & ~mem_ready & expired;
  assign finish    = done_ok | timed_out;

  mem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (~busy | finish | abandon),
    .tick    (busy & ~mem_ready),
    .expired (expired)
  );

  assign mem_valid = busy & sel_valid & ~timed_out;
  assign mem_instr = busy & sel_instr;
  assign mem_addr  = busy ? sel_addr  : 32'h0;
  assign mem_wdata = busy ? sel_wdata : 32'h0;
  assign mem_wstrb = busy ? sel_wstrb : 4'h0;

  assign resp_data = timed_out ? ERR_RDATA : mem_rdata;
  assign m0_ready  = finish & (owner == OWN_M0);
  assign m1_ready  = finish & (owner == OWN_M1);
  assign m0_rdata  = m0_ready ? resp_data : 32'h0;
  assign m1_rdata  = m1_ready ? resp_data : 32'h0;
  assign bus_err   = timed_out;

  // Abandoned requests leave last_owner alone so fairness is not skewed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_M0;
      last_owner <= OWN_M1;
      grant      <= GRANT_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            owner <= winner;
            grant <= owner_grant(winner);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            last_owner <= owner;
            grant      <= GRANT_NONE;
            state      <= IDLE;
          end else if (abandon) begin
            grant <= GRANT_NONE;
            state <= IDLE;
          end
        end
        default: begin
          grant <= GRANT_NONE;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : scoreboard bench for mem_arbiter with a latency-driven slave
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int          TIMEOUT   = 4;
  localparam logic [31:0] ERR_RDATA = 32'hE5E5_E5E5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        m0_valid = 1'b0, m0_instr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_wstrb = '0;
  logic        m0_ready;
  logic [31:0] m0_rdata;

  logic        m1_valid = 1'b0, m1_instr = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_wstrb = '0;
  logic        m1_ready;
  logic [31:0] m1_rdata;

  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  grant;
  logic        bus_err;

  int          slave_lat   = -1;
  int          wait_cnt    = 0;
  logic        force_ready = 1'b0;
  logic [31:0] slave_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          m;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_arbiter #(
    .TIMEOUT   (TIMEOUT),
    .ERR_RDATA (ERR_RDATA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_valid  (m0_valid),
    .m0_instr  (m0_instr),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wstrb  (m0_wstrb),
    .m0_ready  (m0_ready),
    .m0_rdata  (m0_rdata),
    .m1_valid  (m1_valid),
    .m1_instr  (m1_instr),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wstrb  (m1_wstrb),
    .m1_ready  (m1_ready),
    .m1_rdata  (m1_rdata),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .grant     (grant),
    .bus_err   (bus_err)
  );

  // Slave answers slave_lat cycles into a grant; keyed off grant to avoid a loop.
  always @(posedge clk) begin
    if ((grant != 2'b00) && !mem_ready) wait_cnt <= wait_cnt + 1;
    else                                wait_cnt <= 0;
  end
  assign mem_ready = force_ready | ((grant != 2'b00) && (wait_cnt == slave_lat));
  assign mem_rdata = slave_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic sb_pop(input int m, input logic [31:0] rd);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_unexpected_ready", m, 32'hFFFF_FFFF);
      return;
    end
    e = sb.pop_front();
    check("sb_master", m, e.m);
    check("sb_rdata", rd, e.rdata);
    check("sb_bus_err", bus_err, e.err);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (m0_ready && m1_ready) check("both_ready", 1, 0);
      if (m0_ready) sb_pop(0, m0_rdata);
      if (m1_ready) sb_pop(1, m1_rdata);
    end
  end

  task automatic push(input int m, input logic [31:0] rd, input logic err);
    exp_t e;
    e.m = m; e.rdata = rd; e.err = err;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
  endtask

  task automatic wait_grant(input logic [1:0] want);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (grant == want) return;
    end
    check("wait_grant_timeout", grant, want);
  endtask

  task automatic wait_ready(input int m);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_ready) || (m == 1 && m1_ready)) return;
    end
    check("wait_ready_timeout", 0, 1);
  endtask

  logic [1:0] cont_seq [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

  initial begin
    // Reset state
    #2;
    check("rst_grant", grant, 2'b00);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_m0_ready", m0_ready, 0);
    check("rst_m1_ready", m1_ready, 0);
    check("rst_bus_err", bus_err, 0);
    do_reset();

    // Single m0 read, slave answers on the third BUSY cycle
    @(posedge clk); #1;
    m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    slave_lat = 2; slave_rdata = 32'hDEAD_BEEF;
    push(0, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    check("t1_idle_grant", grant, 2'b00);
    @(negedge clk);
    check("t1_grant", grant, 2'b01);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_mem_valid", mem_valid, 1);
    wait_ready(0);
    @(posedge clk); #1 m0_valid = 0;
    @(negedge clk);
    check("t1_release", grant, 2'b00);

    // Continuous contention from reset with a single-cycle slave
    do_reset();
    @(posedge clk); #1;
    m0_valid = 1; m1_valid = 1; m0_addr = 32'h40; m1_addr = 32'h80;
    slave_lat = 0; slave_rdata = 32'h5A5A_0001;
    push(0, 32'h5A5A_0001, 0); push(1, 32'h5A5A_0001, 0);
    push(0, 32'h5A5A_0001, 0); push(1, 32'h5A5A_0001, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("t2_grant_%0d", i), grant, cont_seq[i]);
    end
    @(posedge clk); #1 m0_valid = 0; m1_valid = 0;
    @(negedge clk);

    // m1 write forwarding
    @(posedge clk); #1;
    m1_valid = 1; m1_instr = 0; m1_addr = 32'h20; m1_wdata = 32'h1234_5678; m1_wstrb = 4'b0011;
    slave_lat = 1; slave_rdata = 32'h1111_2222;
    push(1, 32'h1111_2222, 0);
    wait_grant(2'b10);
    check("t3_mem_valid", mem_valid, 1);
    check("t3_mem_addr", mem_addr, 32'h20);
    check("t3_mem_wdata", mem_wdata, 32'h1234_5678);
    check("t3_mem_wstrb", mem_wstrb, 4'b0011);
    check("t3_m0_ready", m0_ready, 0);
    wait_ready(1);
    @(posedge clk); #1 m1_valid = 0; m1_wstrb = 0;

    // Watchdog completion on the 4th BUSY cycle
    @(posedge clk); #1;
    m0_valid = 1; m0_addr = 32'h200; slave_lat = -1; slave_rdata = 32'h7777_7777;
    push(0, ERR_RDATA, 1);
    wait_grant(2'b01);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("t4_mem_valid_%0d", k), mem_valid, (k < 4) ? 1 : 0);
      check($sformatf("t4_m0_ready_%0d", k), m0_ready, (k == 4) ? 1 : 0);
      check($sformatf("t4_bus_err_%0d", k), bus_err, (k == 4) ? 1 : 0);
    end
    @(posedge clk); #1 m0_valid = 0;
    @(negedge clk);
    check("t4_idle", grant, 2'b00);

    // mem_ready on the watchdog's last cycle completes normally
    @(posedge clk); #1;
    m0_valid = 1; slave_lat = 3; slave_rdata = 32'hCAFE_F00D;
    push(0, 32'hCAFE_F00D, 0);
    wait_grant(2'b01);
    repeat (3) @(negedge clk);
    check("t5_m0_ready", m0_ready, 1);
    check("t5_bus_err", bus_err, 0);
    check("t5_mem_valid", mem_valid, 1);
    @(posedge clk); #1 m0_valid = 0;
    @(negedge clk);

    // Reset while m1 owns the bus
    @(posedge clk); #1;
    m1_valid = 1; m1_addr = 32'h300; slave_lat = -1;
    wait_grant(2'b10);
    #2 reset = 0;
    #1;
    check("t6_rst_grant", grant, 2'b00);
    check("t6_rst_mem_valid", mem_valid, 0);
    check("t6_rst_mem_addr", mem_addr, 32'h0);
    check("t6_rst_m1_ready", m1_ready, 0);
    check("t6_rst_bus_err", bus_err, 0);
    m1_valid = 0;
    @(posedge clk); #3 reset = 1;
    @(posedge clk); #1;
    m0_valid = 1; m1_valid = 1; slave_lat = 0; slave_rdata = 32'h0000_00AA;
    push(0, 32'h0000_00AA, 0); push(1, 32'h0000_00AA, 0);
    wait_grant(2'b01);
    check("t6_m0_first", m0_ready, 1);
    @(posedge clk); #1 m0_valid = 0;
    wait_grant(2'b10);
    check("t6_m1_second", m1_ready, 1);
    @(posedge clk); #1 m1_valid = 0;
    @(negedge clk);

    // Abandoned request
    @(posedge clk); #1;
    m0_valid = 1; slave_lat = -1;
    wait_grant(2'b01);
    @(posedge clk); #1 m0_valid = 0;
    @(negedge clk);
    check("t7_m0_ready", m0_ready, 0);
    check("t7_bus_err", bus_err, 0);
    check("t7_mem_valid", mem_valid, 0);
    @(negedge clk);
    check("t7_idle", grant, 2'b00);

    // mem_ready while idle is not forwarded
    @(posedge clk); #1 force_ready = 1;
    @(negedge clk);
    check("t8_m0_ready", m0_ready, 0);
    check("t8_m1_ready", m1_ready, 0);
    check("t8_grant", grant, 2'b00);
    @(posedge clk); #1 force_ready = 0;
    repeat (2) @(negedge clk);

    check("sb_leftover", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter for the core's native valid/ready memory bus.
- Shares a single memory between the `riscv` core (m0) and an auxiliary requester (m1), e.g. a loader or debug port.
- Round-robin grant, held for a whole transaction.
- A watchdog completes any transaction the slave never acknowledges, so masters cannot hang.

Parameters:
- TIMEOUT, 16, max BUSY cycles without mem_ready before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'h0000_0000, read data returned to the master on a timeout completion.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_valid  in  1  m0 request
- m0_instr  in  1  m0 request is an instruction fetch
- m0_addr  in  32  m0 address
- m0_wdata  in  32  m0 write data
- m0_wstrb  in  4  m0 byte strobes; 0 = read
- m0_ready  out  1  m0 completion pulse
- m0_rdata  out  32  m0 read data, valid when m0_ready
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as m0, for m1
- mem_valid  out  1  slave request
- mem_instr  out  1  forwarded instr flag
- mem_addr  out  32  forwarded address
- mem_wdata  out  32  forwarded write data
- mem_wstrb  out  4  forwarded strobes
- mem_ready  in  1  slave completion
- mem_rdata  in  32  slave read data
- grant  out  2  one-hot current owner; 00 when idle
- bus_err  out  1  one-cycle pulse on timeout completion

Behaviour:
- Bus protocol:
  - A master holds valid, instr, addr, wdata and wstrb stable until ready.
  - ready is high for exactly one cycle per transaction.
  - rdata is sampled only while ready is high.
- Reset (async assert, sync release), effective immediately and mid-transaction:
  - state=IDLE, grant=00, last_owner=m1, wait counter=0.
  - mem_valid, m0_ready, m1_ready and bus_err are 0; all data outputs are 0.
  - The outstanding transaction is dropped silently.
- State IDLE:
  - mem_valid=0; both readys=0.
  - Only one master valid: that master wins.
  - Both valid: the master that is not last_owner wins. After reset m0 wins the first tie.
  - Winner is registered into grant; next state is BUSY. Arbitration costs exactly 1 cycle.
- State BUSY:
  - mem_* outputs are a combinational mux of the granted master's signals; mem_valid = granted master's valid.
  - mem_ready and mem_rdata are routed combinationally to the granted master only. The other master's ready stays 0.
  - Wait counter increments each BUSY cycle in which mem_ready=0.
- Exit BUSY to IDLE on any of the following:
  - mem_ready=1: normal completion; last_owner <= owner.
  - TIMEOUT!=0 and counter==TIMEOUT-1 with mem_ready=0:
    - Arbiter asserts the owner's ready for that cycle, rdata=ERR_RDATA, bus_err=1.
    - mem_valid is forced to 0 in that same cycle.
    - last_owner <= owner.
  - Granted master's valid=0 (abandoned request) with mem_ready=0:
    - mem_valid=0 that cycle; no ready and no bus_err.
    - last_owner is unchanged.
  - Counter clears on every entry to IDLE.
- Simultaneous mem_ready and timeout in the same cycle: mem_ready wins, completion is normal, bus_err=0.
- Minimum cycle cost:
  - Back-to-back requests from the same master always pass through one IDLE cycle.
  - A single-cycle slave gives 2 cycles per transaction.
- Fairness: under continuous contention grants strictly alternate m0, m1, m0, ...
- mem_ready arriving while IDLE is ignored and not forwarded.

Decomposition:
- Package mem_arb_pkg holds:
  - state_t enum {IDLE, BUSY}
  - owner_t enum {OWN_M0, OWN_M1}
  - localparam GRANT_NONE = 2'b00
- Sub-module mem_timeout holds the wait counter and compare.
  - Ports: clk, reset, clear, tick, expired.
  - Parameter TIMEOUT; expired is tied to 0 when TIMEOUT==0.
- Muxing and FSM stay in mem_arbiter.

Test Plan:
- Single m0 read:
  - Stimulus: m0_valid, addr=0x100, wstrb=0; slave ready 2 cycles later with rdata=0xDEADBEEF.
  - Required: grant=01 one cycle after valid; m0_ready pulses once with m0_rdata=0xDEADBEEF; m1_ready stays 0; grant returns to 00.
- Contention from reset:
  - Stimulus: m0 and m1 both valid continuously; single-cycle slave.
  - Required: grant sequence is 01,00,10,00,01,...; each master gets one ready per 4 cycles.
- Write forwarding:
  - Stimulus: m1 writes addr=0x20, wdata=0x12345678, wstrb=4'b0011.
  - Required: identical values appear on mem_addr, mem_wdata and mem_wstrb while mem_valid=1.
- Timeout:
  - Stimulus: TIMEOUT=4, slave never ready, m0 reads.
  - Required: on the 4th BUSY cycle m0_ready=1, m0_rdata=ERR_RDATA, bus_err=1, mem_valid=0; next cycle IDLE.
- Tie-break at the limit:
  - Stimulus: mem_ready asserted on the same cycle the counter hits TIMEOUT-1.
  - Required: normal completion with slave rdata; bus_err=0.
- Reset mid-BUSY and abandon:
  - Stimulus: drop reset while m1 is granted.
  - Required: all outputs 0 asynchronously; after release, a simultaneous m0/m1 request grants m0 first.
  - Stimulus: separately, drop m0_valid during BUSY.
  - Required: IDLE next cycle, no m0_ready and no bus_err.
